// File: rtl/antares_imm_pkg.sv
// Shared opcodes, extension mode codes, control states and result payload for the
// Antares-R2 decode-stage immediate controller.
package antares_imm_pkg;

    localparam int unsigned DEF_XLEN     = 32;
    localparam int unsigned DEF_BR_SHIFT = 2;
    localparam int unsigned OPC_W        = 6;
    localparam int unsigned MODE_W       = 3;

    localparam logic [OPC_W-1:0] OP_NOP   = 6'h00;
    localparam logic [OPC_W-1:0] OP_J     = 6'h02;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OPC_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPC_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPC_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OPC_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

    typedef enum logic [MODE_W-1:0] {
        MODE_NONE   = 3'd0,
        MODE_SIGN   = 3'd1,
        MODE_ZERO   = 3'd2,
        MODE_UPPER  = 3'd3,
        MODE_BRANCH = 3'd4,
        MODE_JUMP   = 3'd5
    } imm_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic [31:0] imm;
        imm_mode_e   mode;
        logic [31:0] target;
    } imm_result_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode classification and immediate/target generation for one
// instruction word at a given pc.
module imm_decode
    import antares_imm_pkg::*;
#(
    parameter int unsigned XLEN     = DEF_XLEN,
    parameter int unsigned BR_SHIFT = DEF_BR_SHIFT
) (
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] imm_c,
    output imm_mode_e       mode_c,
    output logic [XLEN-1:0] target_c
);

    logic [OPC_W-1:0] opcode;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  sext;
    logic [XLEN-1:0]  br_off;

    assign opcode   = instr[31:26];
    assign pc_plus4 = pc + XLEN'(4);
    assign sext     = {{16{instr[15]}}, instr[15:0]};
    assign br_off   = sext << BR_SHIFT;

    always_comb begin
        imm_c    = '0;
        mode_c   = MODE_NONE;
        target_c = '0;
        case (opcode)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
                imm_c  = sext;
                mode_c = MODE_SIGN;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                imm_c  = {16'h0, instr[15:0]};
                mode_c = MODE_ZERO;
            end
            OP_LUI: begin
                imm_c  = {instr[15:0], 16'h0};
                mode_c = MODE_UPPER;
            end
            OP_BEQ, OP_BNE: begin
                imm_c    = br_off;
                mode_c   = MODE_BRANCH;
                target_c = pc_plus4 + br_off;
            end
            OP_J, OP_JAL: begin
                imm_c    = {6'h0, instr[25:0]};
                mode_c   = MODE_JUMP;
                target_c = {pc_plus4[31:28], instr[25:0], 2'b00};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_decode_ctrl.sv
// Decode-stage immediate controller: decodes on the input side, then holds results
// in an output register backed by a one-entry skid register.
module imm_decode_ctrl
    import antares_imm_pkg::*;
#(
    parameter int unsigned XLEN     = DEF_XLEN,
    parameter int unsigned BR_SHIFT = DEF_BR_SHIFT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [MODE_W-1:0] out_mode,
    output logic [XLEN-1:0]   out_target
);

    ctrl_state_e state_q, state_d;
    imm_result_t out_q, out_d;
    imm_result_t skid_q, skid_d;
    imm_result_t dec_c;
    logic        accept_c;

    imm_decode #(
        .XLEN     (XLEN),
        .BR_SHIFT (BR_SHIFT)
    ) u_imm_decode (
        .instr    (in_instr),
        .pc       (in_pc),
        .imm_c    (dec_c.imm),
        .mode_c   (dec_c.mode),
        .target_c (dec_c.target)
    );

    // Ready comes straight off the state flop so upstream never sees out_ready.
    assign in_ready  = (state_q != ST_SKID);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept_c  = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        out_d   = dec_c;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready && accept_c) begin
                        out_d = dec_c;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end else if (accept_c) begin
                        skid_d  = dec_c;
                        state_d = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        out_d   = skid_q;
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign out_imm    = out_q.imm;
    assign out_mode   = out_q.mode;
    assign out_target = out_q.target;

endmodule
